// File: rtl/axi4_stream_pkt_arbiter_if.sv
// axi4_stream_if: AXI4-Stream bundle shared by the packet arbiter and its
// sources/sink.
//   master : drives tvalid/tdata/tstrb/tkeep/tlast/tuser/tdest/tid, samples tready
//   slave  : samples the payload, drives tready
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic [DEST_WIDTH-1:0] tdest;
  logic [ID_WIDTH-1:0]   tid;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_arbiter.sv
// axi4_stream_pkt_arbiter: merges INPUTS AXI4-Stream packet sources onto one
// registered AXI4-Stream output, one whole packet at a time, round-robin.
//   clk_i  : single clock
//   rst_i  : asynchronous reset, active low
//   pkt_i  : [INPUTS] requesting streams (slave side)
//   pkt_o  : merged output stream (master side, registered)
// Optional: define AXI4_STREAM_PKT_ARB_TDEST_TAG_EN to replace the output
// tdest with the index of the granted input.
module axi4_stream_pkt_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int INPUTS     = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  pkt_i [INPUTS],
  axi4_stream_if.master pkt_o
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_WIDTH-1:0]   grant_q, grant_d;
  logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;

  // Flattened view of the interface array so it can be indexed by grant_q.
  logic [INPUTS-1:0]      in_valid;
  logic [INPUTS-1:0]      in_last;
  logic [INPUTS-1:0]      in_ready;
  logic [DATA_WIDTH-1:0]  in_data [INPUTS];
  logic [KEEP_WIDTH-1:0]  in_strb [INPUTS];
  logic [KEEP_WIDTH-1:0]  in_keep [INPUTS];
  logic [USER_WIDTH-1:0]  in_user [INPUTS];
  logic [ID_WIDTH-1:0]    in_id   [INPUTS];

  for (genvar g = 0; g < INPUTS; g++) begin : g_in
    assign in_valid[g]     = pkt_i[g].tvalid;
    assign in_last[g]      = pkt_i[g].tlast;
    assign in_data[g]      = pkt_i[g].tdata;
    assign in_strb[g]      = pkt_i[g].tstrb;
    assign in_keep[g]      = pkt_i[g].tkeep;
    assign in_user[g]      = pkt_i[g].tuser;
    assign in_id[g]        = pkt_i[g].tid;
    assign pkt_i[g].tready = in_ready[g];
  end

  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [KEEP_WIDTH-1:0]  sel_strb;
  logic [KEEP_WIDTH-1:0]  sel_keep;
  logic [USER_WIDTH-1:0]  sel_user;
  logic [ID_WIDTH-1:0]    sel_id;
  logic [DEST_WIDTH-1:0]  sel_dest;

  assign sel_valid = in_valid[grant_q];
  assign sel_last  = in_last[grant_q];
  assign sel_data  = in_data[grant_q];
  assign sel_strb  = in_strb[grant_q];
  assign sel_keep  = in_keep[grant_q];
  assign sel_user  = in_user[grant_q];
  assign sel_id    = in_id[grant_q];

`ifdef AXI4_STREAM_PKT_ARB_TDEST_TAG_EN
  if (DEST_WIDTH < $clog2(INPUTS)) begin : g_dest_width_check
    $error("DEST_WIDTH too narrow to carry the grant index");
  end
  assign sel_dest = DEST_WIDTH'(grant_q);
`else
  logic [DEST_WIDTH-1:0]  in_dest [INPUTS];
  for (genvar g = 0; g < INPUTS; g++) begin : g_dest
    assign in_dest[g] = pkt_i[g].tdest;
  end
  assign sel_dest = in_dest[grant_q];
`endif

  // Output register
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [KEEP_WIDTH-1:0]  out_strb;
  logic [KEEP_WIDTH-1:0]  out_keep;
  logic                   out_last;
  logic [USER_WIDTH-1:0]  out_user;
  logic [DEST_WIDTH-1:0]  out_dest;
  logic [ID_WIDTH-1:0]    out_id;

  logic                   slot_free;
  logic                   accept;

  assign slot_free = !out_valid || pkt_o.tready;
  assign accept    = (state_q == ST_GRANT) && sel_valid && slot_free;

  // Round-robin search: first requester strictly after the last grant.
  logic                   req_found;
  logic [PTR_WIDTH-1:0]   req_idx;

  always_comb begin : p_search
    int unsigned cand;
    cand      = 0;
    req_found = 1'b0;
    req_idx   = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      cand = (32'(ptr_q) + 1 + i) % INPUTS;
      if (!req_found && in_valid[PTR_WIDTH'(cand)]) begin
        req_found = 1'b1;
        req_idx   = PTR_WIDTH'(cand);
      end
    end
  end

  always_comb begin : p_fsm
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    in_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          state_d = ST_GRANT;
          grant_d = req_idx;
          ptr_d   = req_idx;
        end
      end
      ST_GRANT: begin
        in_ready[grant_q] = slot_free;
        if (accept && sel_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_WIDTH'(INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= '0;
      out_dest  <= '0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_strb  <= sel_strb;
      out_keep  <= sel_keep;
      out_last  <= sel_last;
      out_user  <= sel_user;
      out_dest  <= sel_dest;
      out_id    <= sel_id;
    end else if (pkt_o.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tdata  = out_data;
  assign pkt_o.tstrb  = out_strb;
  assign pkt_o.tkeep  = out_keep;
  assign pkt_o.tlast  = out_last;
  assign pkt_o.tuser  = out_user;
  assign pkt_o.tdest  = out_dest;
  assign pkt_o.tid    = out_id;
endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// tb_axi4_stream_pkt_arbiter: self-checking bench for axi4_stream_pkt_arbiter.
// Sources are queues of beats; expected output order comes from a packet-level
// round-robin model (or from a table of hand-derived grant orders).
module tb_axi4_stream_pkt_arbiter;
  localparam int DW  = 32;
  localparam int UW  = 2;
  localparam int DSW = 2;
  localparam int IW  = 3;
  localparam int N   = 4;

  typedef struct packed {
    logic [1:0]     src;
    logic           first;
    logic           last;
    logic [DW-1:0]  data;
    logic [3:0]     strb;
    logic [3:0]     keep;
    logic [UW-1:0]  user;
    logic [DSW-1:0] dest;
    logic [IW-1:0]  id;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [3:0]     strb;
    logic [3:0]     keep;
    logic           last;
    logic [UW-1:0]  user;
    logic [DSW-1:0] dest;
    logic [IW-1:0]  id;
  } obs_t;

  typedef struct packed {
    logic [3:0]      mask;
    logic [2:0]      n;
    logic [3:0][1:0] order;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  axi4_stream_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(DSW), .ID_WIDTH(IW)) pkt_in [N] ();
  axi4_stream_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(DSW), .ID_WIDTH(IW)) pkt_out ();

  axi4_stream_pkt_arbiter #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .INPUTS(N)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pkt_i (pkt_in),
    .pkt_o (pkt_out)
  );

  logic [N-1:0] src_valid = '0;
  logic [N-1:0] src_ready;
  beat_t        src_cur [N];
  logic         out_ready = 1'b1;

  for (genvar g = 0; g < N; g++) begin : g_src
    assign pkt_in[g].tvalid = src_valid[g];
    assign pkt_in[g].tdata  = src_cur[g].data;
    assign pkt_in[g].tstrb  = src_cur[g].strb;
    assign pkt_in[g].tkeep  = src_cur[g].keep;
    assign pkt_in[g].tlast  = src_cur[g].last;
    assign pkt_in[g].tuser  = src_cur[g].user;
    assign pkt_in[g].tdest  = src_cur[g].dest;
    assign pkt_in[g].tid    = src_cur[g].id;
    assign src_ready[g]     = pkt_in[g].tready;
  end
  assign pkt_out.tready = out_ready;

  obs_t obs_now;
  assign obs_now = {pkt_out.tdata, pkt_out.tstrb, pkt_out.tkeep, pkt_out.tlast,
                    pkt_out.tuser, pkt_out.tdest, pkt_out.tid};

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    nbeat = 0;
  int    m_ptr = N - 1;
  int    gap_pct = 0;
  int    out_mode = 0;
  int    rcnt = 0;
  int    pause_cfg [N];
  int    pause_left [N];
  beat_t src_q [N][$];
  beat_t pend [N][$];
  beat_t exp_q [$];
  int    acc_cyc [$];
  bit    stall_prev = 0;
  obs_t  stall_obs;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic obs_t exp_obs(input beat_t b);
    obs_t o;
    o.data = b.data;
    o.strb = b.strb;
    o.keep = b.keep;
    o.last = b.last;
    o.user = b.user;
    o.id   = b.id;
`ifdef AXI4_STREAM_PKT_ARB_TDEST_TAG_EN
    o.dest = DSW'(b.src);
`else
    o.dest = b.dest;
`endif
    return o;
  endfunction

  function automatic beat_t mk_beat(input int src, input logic [31:0] data,
                                    input bit first, input bit last, input int dest);
    beat_t b;
    b.src   = 2'(src);
    b.first = first;
    b.last  = last;
    b.data  = data;
    b.strb  = 4'($urandom);
    b.keep  = 4'($urandom);
    b.user  = UW'($urandom);
    b.id    = IW'($urandom);
    b.dest  = (dest < 0) ? DSW'($urandom) : DSW'(dest);
    return b;
  endfunction

  task automatic add_pkt(input int src, input int len, input logic [31:0] base,
                         input logic [31:0] step, input int dest);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = mk_beat(src, base + 32'(i) * step, i == 0, i == len - 1, dest);
      src_q[src].push_back(b);
      pend[src].push_back(b);
    end
  endtask

  // Packet-level round robin over sources that all hold pending packets.
  task automatic schedule();
    bit    found;
    int    k;
    beat_t b;
    found = 1;
    while (found) begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && pend[k].size() > 0) begin
          found = 1;
          m_ptr = k;
        end
      end
      if (found) begin
        do begin
          b = pend[m_ptr].pop_front();
          exp_q.push_back(b);
        end while (!b.last && pend[m_ptr].size() > 0);
      end
    end
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      pend[k].delete();
      pause_left[k] = 0;
    end
    exp_q.delete();
    stall_prev = 0;
    m_ptr = N - 1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    flush();
    repeat (2) @(negedge clk_i);
    check("rst_tvalid", 64'(pkt_out.tvalid), 64'd0);
    check("rst_tready", 64'(src_ready), 64'd0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  function automatic bit src_busy();
    bit busy = 0;
    for (int k = 0; k < N; k++) if (src_q[k].size() > 0) busy = 1;
    return busy;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk_i);
  endtask

  // Source driver and output monitor
  initial begin
    logic [N-1:0] hs;
    beat_t        b;
    for (int k = 0; k < N; k++) begin
      pause_cfg[k]  = 0;
      pause_left[k] = 0;
      src_cur[k]    = '0;
    end
    forever begin
      @(negedge clk_i);
      hs = src_valid & src_ready;
      if (rst_i) begin
        check("one_ready", 64'($countones(src_ready) <= 1), 64'd1);
        if (stall_prev) check("stall_hold", {15'd0, pkt_out.tvalid, obs_now}, {15'd0, 1'b1, stall_obs});
        if (pkt_out.tvalid && out_ready) begin
          acc_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check($sformatf("extra_beat%0d", nbeat), 64'(obs_now), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            b = exp_q.pop_front();
            check($sformatf("beat%0d", nbeat), 64'(obs_now), 64'(exp_obs(b)));
          end
          nbeat++;
        end
        stall_prev = pkt_out.tvalid && !out_ready;
        stall_obs  = obs_now;
      end else begin
        stall_prev = 0;
      end
      @(posedge clk_i);
      cyc++;
      #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && src_q[k].size() > 0) begin
          b = src_q[k].pop_front();
          if (b.first) pause_left[k] = pause_cfg[k];
        end
        if (src_q[k].size() == 0) begin
          src_valid[k] = 1'b0;
        end else begin
          src_cur[k] = src_q[k][0];
          if (src_cur[k].first) src_valid[k] = 1'b1;
          else if (src_valid[k] && !hs[k]) src_valid[k] = 1'b1;
          else if (pause_left[k] > 0) begin
            src_valid[k] = 1'b0;
            pause_left[k]--;
          end else src_valid[k] = ($urandom_range(99) >= gap_pct);
        end
      end
      case (out_mode)
        1:       out_ready = ($urandom_range(99) < 70);
        2:       out_ready = (rcnt % 3 == 0);
        default: out_ready = 1'b1;
      endcase
      rcnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  vec_t  vecs [8];
  beat_t vb [N];

  function automatic vec_t mkvec(input logic [3:0] mask, input int n,
                                 input int o0, input int o1, input int o2, input int o3);
    vec_t v;
    v.mask = mask;
    v.n = 3'(n);
    v.order[0] = 2'(o0);
    v.order[1] = 2'(o1);
    v.order[2] = 2'(o2);
    v.order[3] = 2'(o3);
    return v;
  endfunction

  initial begin
    int t_in, t_out;
    // Grant orders carried across entries; pointer starts at 3 after reset.
    vecs[0] = mkvec(4'b0100, 1, 2, 0, 0, 0);
    vecs[1] = mkvec(4'b1011, 3, 3, 0, 1, 0);
    vecs[2] = mkvec(4'b1111, 4, 2, 3, 0, 1);
    vecs[3] = mkvec(4'b0101, 2, 2, 0, 0, 0);
    vecs[4] = mkvec(4'b0011, 2, 1, 0, 0, 0);
    vecs[5] = mkvec(4'b1001, 2, 3, 0, 0, 0);
    vecs[6] = mkvec(4'b0001, 1, 0, 0, 0, 0);
    vecs[7] = mkvec(4'b0110, 2, 1, 2, 0, 0);

    // Reset state
    do_reset();
    check("reset_tvalid", 64'(pkt_out.tvalid), 64'd0);
    check("reset_fields", 64'(obs_now), 64'd0);
    check("reset_tready", 64'(src_ready), 64'd0);

    // Input 2, three beats, latency from request to output
    add_pkt(2, 3, 32'h11, 32'h11, -1);
    schedule();
    t_in = -1;
    t_out = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (t_in < 0 && src_valid[2]) t_in = cyc;
      if (t_out < 0 && pkt_out.tvalid) t_out = cyc;
    end
    check("latency", 64'(t_out - t_in), 64'd2);
    wait_drain(50, "single");

    // All four inputs with 2-beat packets: order 0,1,2,3,... and 2 beats per 3 cycles
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < N; k++) add_pkt(k, 2, 32'h1000 * (r + 1) + 32'(k * 16), 1, -1);
    schedule();
    acc_cyc.delete();
    wait_drain(200, "rr");
    check("rr_beats", 64'(acc_cyc.size()), 64'd24);
    if (acc_cyc.size() == 24) check("rr_span", 64'(acc_cyc[23] - acc_cyc[0]), 64'd34);

    // Input 1, four beats with output backpressure 1,0,0 repeating
    out_mode = 2;
    rcnt = 0;
    add_pkt(1, 4, 32'hA5A5_0000, 32'h0101, -1);
    schedule();
    wait_drain(100, "stall");
    out_mode = 0;

    // Input 0 pauses mid-packet while input 3 waits
    do_reset();
    pause_cfg[0] = 5;
    add_pkt(0, 4, 32'h0B00, 1, -1);
    add_pkt(3, 2, 32'h3B00, 1, -1);
    schedule();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      check($sformatf("hold3_c%0d", c), 64'(src_ready[3]), 64'd0);
    end
    wait_drain(100, "pause");
    pause_cfg[0] = 0;

    // Asynchronous reset in the middle of a packet
    do_reset();
    add_pkt(0, 6, 32'h6000, 1, -1);
    schedule();
    acc_cyc.delete();
    for (int c = 0; c < 20 && acc_cyc.size() < 2; c++) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    check("pre_rst_tvalid", 64'(pkt_out.tvalid), 64'd1);
    rst_i = 1'b0;
    flush();
    #1;
    check("async_tvalid", 64'(pkt_out.tvalid), 64'd0);
    check("async_fields", 64'(obs_now), 64'd0);
    check("async_tready", 64'(src_ready), 64'd0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    add_pkt(0, 1, 32'h7000, 1, -1);
    add_pkt(1, 1, 32'h7100, 1, -1);
    schedule();
    wait_drain(50, "post_rst");

    // tdest handling on input 3 with tdest=0
    do_reset();
    add_pkt(3, 2, 32'hD000, 1, 0);
    schedule();
    wait_drain(50, "tdest");

    // Table of simultaneous single-beat requests and expected grant orders
    do_reset();
    for (int e = 0; e < 8; e++) begin
      for (int k = 0; k < N; k++) begin
        if (vecs[e].mask[k]) begin
          vb[k] = mk_beat(k, 32'hC000_0000 | (32'(e) << 16) | 32'(k), 1'b1, 1'b1, -1);
          src_q[k].push_back(vb[k]);
        end
      end
      for (int i = 0; i < int'(vecs[e].n); i++) exp_q.push_back(vb[vecs[e].order[i]]);
      wait_drain(100, $sformatf("vec%0d", e));
    end

    // Randomized traffic against the packet-level model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      out_mode = 1;
      gap_pct = 25;
      for (int k = 0; k < N; k++) begin
        int np = $urandom_range(0, 4);
        for (int p = 0; p < np; p++)
          add_pkt(k, $urandom_range(1, 4), $urandom, 32'h0100_0001, -1);
      end
      schedule();
      wait_drain(3000, $sformatf("rand%0d", r));
    end
    out_mode = 0;
    gap_pct = 0;

    repeat (4) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
